// File: rtl/pc_ras.sv
// Program counter with fetch stall and a circular return-address stack.
// Define PC_TRAP_EN to add the trap input, the trap vector and the epc output.
module pc_ras #(
  parameter int                XLEN      = 16,
  parameter int                IMM_W     = 7,
  parameter int                RAS_DEPTH = 4,
  parameter logic [XLEN-1:0]   RESET_VEC = '0
`ifdef PC_TRAP_EN
  ,
  parameter logic [XLEN-1:0]   TRAP_VEC  = XLEN'(16'h0004)
`endif
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall_i,
  input  logic [2:0]                       sel_i,
  input  logic [IMM_W-1:0]                 imm_i,
  input  logic [XLEN-1:0]                  alu_out_i,
`ifdef PC_TRAP_EN
  input  logic                             trap_i,
  output logic [XLEN-1:0]                  epc_o,
`endif
  output logic [XLEN-1:0]                  pc_o,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count_o,
  output logic                             ras_ovf_o,
  output logic                             ras_unf_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH+1);

  localparam logic [2:0] SEL_SEQ    = 3'b000;
  localparam logic [2:0] SEL_BRANCH = 3'b001;
  localparam logic [2:0] SEL_JALR   = 3'b010;
  localparam logic [2:0] SEL_CALL   = 3'b011;
  localparam logic [2:0] SEL_RET    = 3'b100;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push;
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];

  logic [XLEN-1:0]  pc_plus1;
  logic [XLEN-1:0]  imm_sext;
  logic [PTR_W-1:0] top_inc;
  logic [PTR_W-1:0] top_dec;

`ifdef PC_TRAP_EN
  logic [XLEN-1:0]  epc_q, epc_d;
`endif

  assign pc_plus1 = pc_q + XLEN'(1);
  assign imm_sext = {{(XLEN-IMM_W){imm_i[IMM_W-1]}}, imm_i};
  // Depth is a power of two, so pointer arithmetic wraps for free.
  assign top_inc  = top_q + PTR_W'(1);
  assign top_dec  = top_q - PTR_W'(1);

  always_comb begin
    pc_d  = pc_q;
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    push  = 1'b0;
`ifdef PC_TRAP_EN
    epc_d = epc_q;
`endif
    if (!stall_i) begin
      case (sel_i)
        SEL_SEQ:    pc_d = pc_plus1;
        SEL_BRANCH: pc_d = pc_plus1 + imm_sext;
        SEL_JALR:   pc_d = alu_out_i;
        SEL_CALL: begin
          pc_d  = alu_out_i;
          push  = 1'b1;
          top_d = top_inc;
          // Full stack: the new entry lands on the oldest one.
          if (cnt_q == CNT_W'(RAS_DEPTH)) ovf_d = 1'b1;
          else                             cnt_d = cnt_q + CNT_W'(1);
        end
        SEL_RET: begin
          if (cnt_q != '0) begin
            pc_d  = ras_q[top_q];
            top_d = top_dec;
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            pc_d  = alu_out_i;
            unf_d = 1'b1;
          end
        end
        default:    pc_d = pc_plus1;
      endcase
    end
`ifdef PC_TRAP_EN
    if (trap_i) begin
      pc_d  = TRAP_VEC;
      epc_d = pc_q;
      top_d = top_q;
      cnt_d = cnt_q;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      push  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_VEC;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
`ifdef PC_TRAP_EN
      epc_q <= '0;
`endif
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
`ifdef PC_TRAP_EN
      epc_q <= epc_d;
`endif
    end
  end

  // Entry storage needs no reset; validity is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push) ras_q[top_inc] <= pc_plus1;
  end

  assign pc_o        = pc_q;
  assign ras_count_o = cnt_q;
  assign ras_ovf_o   = ovf_q;
  assign ras_unf_o   = unf_q;
`ifdef PC_TRAP_EN
  assign epc_o       = epc_q;
`endif

endmodule

// File: tb/tb_pc_ras.sv
// Directed and random stimulus for pc_ras, checked against a queue-based model.
module tb_pc_ras;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  sel;
  logic [6:0]  imm;
  logic [15:0] alu_out;
  logic [15:0] pc;
  logic [2:0]  ras_count;
  logic        ras_ovf;
  logic        ras_unf;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] m_pc;
  logic [15:0] m_ras[$];
  logic        m_ovf;
  logic        m_unf;

  pc_ras dut (
    .clk         (clk),
    .reset       (reset),
    .stall_i     (stall),
    .sel_i       (sel),
    .imm_i       (imm),
    .alu_out_i   (alu_out),
    .pc_o        (pc),
    .ras_count_o (ras_count),
    .ras_ovf_o   (ras_ovf),
    .ras_unf_o   (ras_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = 16'h0000;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},  32'(pc),        32'(m_pc));
    chk({tag, ".cnt"}, 32'(ras_count), 32'(m_ras.size()));
    chk({tag, ".ovf"}, 32'(ras_ovf),   32'(m_ovf));
    chk({tag, ".unf"}, 32'(ras_unf),   32'(m_unf));
  endtask

  // One clock: apply inputs, advance the model by the architectural rules, compare.
  task automatic step(input string tag, input logic st, input logic [2:0] s,
                      input logic [6:0] im, input logic [15:0] alu);
    int off;
    stall   = st;
    sel     = s;
    imm     = im;
    alu_out = alu;
    @(posedge clk);
    #1;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (!st) begin
      case (s)
        3'd1: begin
          off  = im[6] ? int'(im) - 128 : int'(im);
          m_pc = 16'(int'(m_pc) + 1 + off);
        end
        3'd2: m_pc = alu;
        3'd3: begin
          m_ras.push_back(16'(m_pc + 16'd1));
          if (m_ras.size() > DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
          m_pc = alu;
        end
        3'd4: begin
          if (m_ras.size() > 0) m_pc = m_ras.pop_back();
          else begin
            m_pc  = alu;
            m_unf = 1'b1;
          end
        end
        default: m_pc = 16'(m_pc + 16'd1);
      endcase
    end
    check_all(tag);
  endtask

  initial begin
    reset   = 1'b0;
    stall   = 1'b0;
    sel     = 3'd0;
    imm     = '0;
    alu_out = '0;
    model_reset();
    #12;
    reset = 1'b1;
    #1;
    check_all("reset");

    step("seq1", 1'b0, 3'd0, 7'h00, 16'h0000);
    chk("seq1_const", 32'(pc), 32'd1);
    step("seq2", 1'b0, 3'd0, 7'h00, 16'h0000);
    step("seq3", 1'b0, 3'd0, 7'h00, 16'h0000);
    chk("seq3_const", 32'(pc), 32'd3);

    // Asynchronous reset between clock edges.
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst_pc", 32'(pc), 32'd0);
    check_all("async_rst");
    #1 reset = 1'b1;

    step("to10a", 1'b0, 3'd2, 7'h00, 16'd10);
    step("br_neg", 1'b0, 3'd1, 7'h7D, 16'h0000);
    chk("br_neg_const", 32'(pc), 32'd8);
    step("to10b", 1'b0, 3'd2, 7'h00, 16'd10);
    step("br_pos", 1'b0, 3'd1, 7'h3F, 16'h0000);
    chk("br_pos_const", 32'(pc), 32'd74);
    step("toffff", 1'b0, 3'd2, 7'h00, 16'hFFFF);
    step("wrap", 1'b0, 3'd0, 7'h00, 16'h0000);
    chk("wrap_const", 32'(pc), 32'd0);

    step("to20", 1'b0, 3'd2, 7'h00, 16'd20);
    step("call", 1'b0, 3'd3, 7'h00, 16'd100);
    chk("call_pc", 32'(pc), 32'd100);
    chk("call_cnt", 32'(ras_count), 32'd1);
    step("ret", 1'b0, 3'd4, 7'h00, 16'h0000);
    chk("ret_pc", 32'(pc), 32'd21);
    chk("ret_cnt", 32'(ras_count), 32'd0);

    step("to1", 1'b0, 3'd2, 7'h00, 16'd1);
    for (int i = 2; i <= 6; i++) begin
      step("ovf_call", 1'b0, 3'd3, 7'h00, 16'(i));
      chk("ovf_flag", 32'(ras_ovf), (i == 6) ? 32'd1 : 32'd0);
    end
    chk("ovf_cnt", 32'(ras_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step("ovf_ret", 1'b0, 3'd4, 7'h00, 16'h0000);
      chk("ovf_ret_pc", 32'(pc), 32'(6 - i));
    end

    step("unf", 1'b0, 3'd4, 7'h00, 16'h0200);
    chk("unf_pc", 32'(pc), 32'h0200);
    chk("unf_flag", 32'(ras_unf), 32'd1);
    chk("unf_cnt", 32'(ras_count), 32'd0);
    step("unf_clr", 1'b0, 3'd0, 7'h00, 16'h0000);
    chk("unf_pulse", 32'(ras_unf), 32'd0);

    step("st_c1", 1'b0, 3'd3, 7'h00, 16'd30);
    step("st_c2", 1'b0, 3'd3, 7'h00, 16'd50);
    for (int i = 0; i < 3; i++) begin
      step("stall", 1'b1, 3'd3, 7'h00, 16'd77);
      chk("stall_pc", 32'(pc), 32'd50);
      chk("stall_cnt", 32'(ras_count), 32'd2);
    end
    step("unstall", 1'b0, 3'd3, 7'h00, 16'd77);
    chk("unstall_pc", 32'(pc), 32'd77);
    chk("unstall_cnt", 32'(ras_count), 32'd3);

    for (int n = 0; n < 400; n++) begin
      step("rand", ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
           7'($urandom), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
